keypad_entry: RTL and testbench

- Operator-input front end for the bottling controller: scans a 4x4 matrix keypad, debounces keys and accumulates up to 4 decimal digits.
- On the confirm key it presents the value on temp_data and raises an ack level, which the controller consumes to set bottle count and pills per bottle.
- It is the producer side of the controller's temp_data/ack interface.

---
 rtl/keypad_pkg.sv | 66 ++++++
 rtl/keypad_scan.sv | 135 +++++++++++++
 rtl/keypad_entry.sv | 170 +++++++++++++++++
 tb/tb_keypad_entry.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared key codes, keypad map, entry FSM encoding and default timing for
// the keypad operator-entry front end.
package keypad_pkg;

   localparam int unsigned SCAN_DIV_DEF       = 100_000;
   localparam int unsigned DEBOUNCE_SCANS_DEF = 20;
   localparam int unsigned ACK_HOLD_DEF       = 1_000_000;
   localparam int unsigned ACK_GAP_DEF        = 3_000_000;
   localparam int unsigned MAX_VAL_DEF        = 9999;

   localparam logic [4:0] KEY_0     = 5'd0;
   localparam logic [4:0] KEY_1     = 5'd1;
   localparam logic [4:0] KEY_2     = 5'd2;
   localparam logic [4:0] KEY_3     = 5'd3;
   localparam logic [4:0] KEY_4     = 5'd4;
   localparam logic [4:0] KEY_5     = 5'd5;
   localparam logic [4:0] KEY_6     = 5'd6;
   localparam logic [4:0] KEY_7     = 5'd7;
   localparam logic [4:0] KEY_8     = 5'd8;
   localparam logic [4:0] KEY_9     = 5'd9;
   localparam logic [4:0] KEY_A     = 5'd10;
   localparam logic [4:0] KEY_B     = 5'd11;
   localparam logic [4:0] KEY_C     = 5'd12;
   localparam logic [4:0] KEY_D     = 5'd13;
   localparam logic [4:0] KEY_STAR  = 5'd14;
   localparam logic [4:0] KEY_HASH  = 5'd15;
   localparam logic [4:0] KEY_NONE  = 5'd16;
   localparam logic [4:0] KEY_GHOST = 5'd17;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACK_HI = 2'd1,
      ST_GAP    = 2'd2
   } entry_state_e;

   // Physical (row, col) position to key code.
   function automatic logic [4:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [4:0] code;
      case ({row, col})
         4'h0:    code = KEY_1;
         4'h1:    code = KEY_2;
         4'h2:    code = KEY_3;
         4'h3:    code = KEY_A;
         4'h4:    code = KEY_4;
         4'h5:    code = KEY_5;
         4'h6:    code = KEY_6;
         4'h7:    code = KEY_B;
         4'h8:    code = KEY_7;
         4'h9:    code = KEY_8;
         4'hA:    code = KEY_9;
         4'hB:    code = KEY_C;
         4'hC:    code = KEY_STAR;
         4'hD:    code = KEY_0;
         4'hE:    code = KEY_HASH;
         default: code = KEY_D;
      endcase
      return code;
   endfunction

   // Four BCD nibbles to binary; at most 9999, so 14 bits suffice.
   function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
      return 14'(bcd[15:12]) * 14'd1000 + 14'(bcd[11:8]) * 14'd100
           + 14'(bcd[7:4]) * 14'd10 + 14'(bcd[3:0]);
   endfunction

endpackage

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: rotates the column drive, synchronises the rows,
// decodes one code per full frame and debounces press/release into a
// single-cycle key event.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = SCAN_DIV_DEF,
   parameter int unsigned DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [3:0] key_row,
   output logic [3:0] key_col,
   output logic       key_evt,
   output logic [4:0] key_code
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DB_W  = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]  DB_RELOAD  = DB_W'(DEBOUNCE_SCANS - 1);

   logic [3:0]       row_meta_q, row_sync_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       col_q, col_d;
   logic [1:0]       fhits_q, fhits_d;
   logic [4:0]       fcode_q, fcode_d;
   logic [4:0]       prev_q, prev_d;
   logic [DB_W-1:0]  run_q, run_d;
   logic             armed_q, armed_d;
   logic             evt_q, evt_d;
   logic [4:0]       code_q, code_d;

   logic [1:0] slot_hits, base_hits, merged_hits;
   logic [2:0] sum_hits;
   logic [4:0] slot_code, base_code, merged_code, frame_res, frame_eff;
   logic       slot_end, frame_done;

   // Two-flop synchroniser for the asynchronous row inputs
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
      end else begin
         row_meta_q <= key_row;
         row_sync_q <= row_meta_q;
      end
   end

   // Count and identify keys pulled low in the currently driven column
   always_comb begin
      slot_hits = 2'd0;
      slot_code = KEY_NONE;
      for (int r = 0; r < 4; r++) begin
         if (!row_sync_q[r]) begin
            if (slot_hits != 2'd2) slot_hits = slot_hits + 2'd1;
            slot_code = key_map(2'(r), col_q);
         end
      end
   end

   // Slot timer, column rotation and per-frame accumulation (hits saturate at 2)
   always_comb begin
      slot_end    = (div_q == '0);
      frame_done  = slot_end && (col_q == 2'd3);
      div_d       = slot_end ? DIV_RELOAD : div_q - DIV_W'(1);
      col_d       = slot_end ? col_q + 2'd1 : col_q;
      base_hits   = (col_q == 2'd0) ? 2'd0 : fhits_q;
      base_code   = (col_q == 2'd0) ? KEY_NONE : fcode_q;
      sum_hits    = {1'b0, base_hits} + {1'b0, slot_hits};
      merged_hits = (sum_hits >= 3'd2) ? 2'd2 : sum_hits[1:0];
      merged_code = (slot_hits != 2'd0) ? slot_code : base_code;
      fhits_d     = slot_end ? merged_hits : fhits_q;
      fcode_d     = slot_end ? merged_code : fcode_q;
      case (merged_hits)
         2'd0:    frame_res = KEY_NONE;
         2'd1:    frame_res = merged_code;
         default: frame_res = KEY_GHOST;
      endcase
      frame_eff = (frame_res == KEY_GHOST) ? KEY_NONE : frame_res;
   end

   // Debounce: a code must repeat for DEBOUNCE_SCANS frames; one press per arm
   always_comb begin
      prev_d  = prev_q;
      run_d   = run_q;
      armed_d = armed_q;
      evt_d   = 1'b0;
      code_d  = code_q;
      if (frame_done) begin
         prev_d = frame_eff;
         if (frame_eff != prev_q)  run_d = DB_RELOAD;
         else if (run_q != '0)     run_d = run_q - DB_W'(1);
         if (run_d == '0) begin
            if (armed_q && (frame_eff != KEY_NONE)) begin
               evt_d   = 1'b1;
               code_d  = frame_eff;
               armed_d = 1'b0;
            end else if (!armed_q && (frame_eff == KEY_NONE)) begin
               armed_d = 1'b1;
            end
         end
      end
   end

   // Scanner and debounce state registers
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         div_q   <= DIV_RELOAD;
         col_q   <= 2'd0;
         fhits_q <= 2'd0;
         fcode_q <= KEY_NONE;
         prev_q  <= KEY_NONE;
         run_q   <= '0;
         armed_q <= 1'b1;
         evt_q   <= 1'b0;
         code_q  <= KEY_NONE;
      end else begin
         div_q   <= div_d;
         col_q   <= col_d;
         fhits_q <= fhits_d;
         fcode_q <= fcode_d;
         prev_q  <= prev_d;
         run_q   <= run_d;
         armed_q <= armed_d;
         evt_q   <= evt_d;
         code_q  <= code_d;
      end
   end

   assign key_col  = ~(4'b0001 << col_q);
   assign key_evt  = evt_q;
   assign key_code = code_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry front end: collects up to four BCD digits from debounced key
// events, presents the binary value on temp_data and hands it over with an
// ack level followed by a key-discard gap.
//
// state     | meaning
// ST_IDLE   | accepting keys, waiting for confirm
// ST_ACK_HI | ack high, value frozen for the controller
// ST_GAP    | ack low, keys discarded while the controller releases
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = SCAN_DIV_DEF,
   parameter int unsigned DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF,
   parameter int unsigned ACK_HOLD       = ACK_HOLD_DEF,
   parameter int unsigned ACK_GAP        = ACK_GAP_DEF,
   parameter int unsigned MAX_VAL        = MAX_VAL_DEF
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [3:0]  key_row,
   output logic [3:0]  key_col,
   output logic [13:0] temp_data,
   output logic        ack,
   output logic [2:0]  digit_cnt,
   output logic        entry_err
);

   localparam int unsigned T_MAX = (ACK_HOLD > ACK_GAP) ? ACK_HOLD : ACK_GAP;
   localparam int unsigned T_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam logic [T_W-1:0] HOLD_RELOAD = T_W'(ACK_HOLD - 1);
   localparam logic [T_W-1:0] GAP_RELOAD  = T_W'(ACK_GAP - 1);

   logic         key_evt;
   logic [4:0]   key_code;

   entry_state_e state_q, state_d;
   logic [T_W-1:0] timer_q, timer_d;

   logic [15:0]  digits_q, digits_d;
   logic [2:0]   cnt_q, cnt_d;
   logic         err_q, err_d;
   logic [13:0]  value_q, value_d;
   logic [13:0]  cur_bin;
   logic [16:0]  cand_bin;

   logic         is_confirm, evt_live, ack_done;

   keypad_scan #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_scan (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_row   (key_row),
      .key_col   (key_col),
      .key_evt   (key_evt),
      .key_code  (key_code)
   );

   assign is_confirm = key_evt && (key_code == KEY_HASH);

   // Entry FSM state and hold/gap timer registers
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // Next state: confirm with digits starts the handshake, timers end each phase
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         ST_IDLE: begin
            if (is_confirm && (cnt_q != 3'd0)) begin
               state_d = ST_ACK_HI;
               timer_d = HOLD_RELOAD;
            end
         end
         ST_ACK_HI: begin
            if (timer_q == '0) begin
               state_d = ST_GAP;
               timer_d = GAP_RELOAD;
            end else begin
               timer_d = timer_q - T_W'(1);
            end
         end
         ST_GAP: begin
            if (timer_q == '0) state_d = ST_IDLE;
            else               timer_d = timer_q - T_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: ack level, key acceptance window and end-of-hold strobe
   always_comb begin
      ack      = (state_q == ST_ACK_HI);
      evt_live = key_evt && (state_q == ST_IDLE);
      ack_done = (state_q == ST_ACK_HI) && (timer_q == '0);
   end

   // Digit editing; keys outside IDLE are dropped without flagging an error
   always_comb begin
      digits_d = digits_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      cur_bin  = bcd_to_bin(digits_q);
      cand_bin = 17'(cur_bin) * 17'd10 + 17'(key_code[3:0]);
      value_d  = cur_bin;
      if (ack_done) begin
         digits_d = '0;
         cnt_d    = 3'd0;
         value_d  = '0;
      end else if (evt_live) begin
         if (key_code <= KEY_9) begin
            if ((cnt_q < 3'd4) && (cand_bin <= 17'(MAX_VAL))) begin
               digits_d = {digits_q[11:0], key_code[3:0]};
               cnt_d    = cnt_q + 3'd1;
               err_d    = 1'b0;
            end else begin
               err_d = 1'b1;
            end
         end else begin
            case (key_code)
               KEY_B: begin
                  if (cnt_q == 3'd0) begin
                     err_d = 1'b1;
                  end else begin
                     digits_d = {4'h0, digits_q[15:4]};
                     cnt_d    = cnt_q - 3'd1;
                     err_d    = 1'b0;
                  end
               end
               KEY_STAR: begin
                  digits_d = '0;
                  cnt_d    = 3'd0;
                  err_d    = 1'b0;
               end
               KEY_HASH: err_d = (cnt_q == 3'd0);
               default:  ;
            endcase
         end
      end
   end

   // Entry datapath registers; temp_data follows the digits by one cycle
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         digits_q <= '0;
         cnt_q    <= 3'd0;
         err_q    <= 1'b0;
         value_q  <= '0;
      end else begin
         digits_q <= digits_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         value_q  <= value_d;
      end
   end

   assign temp_data = value_q;
   assign digit_cnt = cnt_q;
   assign entry_err = err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a physical 4x4 keypad model drives the rows from
// the column drive; a digit-queue model of the entry rules gives expectations.
module tb_keypad_entry;

   localparam int FRAME = 16;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [3:0]  key_row;
   logic [3:0]  key_col;
   logic [13:0] temp_data;
   logic        ack;
   logic [2:0]  digit_cnt;
   logic        entry_err;

   logic [15:0] pressed = '0;
   int          n_tests = 0;
   int          n_failed = 0;
   string       labels = "123A456B789C*0#D";
   int          mq[$];
   bit          merr = 1'b0;

   keypad_entry #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (2),
      .ACK_HOLD       (8),
      .ACK_GAP        (16),
      .MAX_VAL        (9999)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_row   (key_row),
      .key_col   (key_col),
      .temp_data (temp_data),
      .ack       (ack),
      .digit_cnt (digit_cnt),
      .entry_err (entry_err)
   );

   always #5 sys_clk = ~sys_clk;

   // A pressed key shorts its row to its column; rows are pulled up
   always_comb begin
      key_row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int model_val();
      int v = 0;
      foreach (mq[i]) v = v * 10 + mq[i];
      return v;
   endfunction

   function automatic int idx_of(input byte ch);
      for (int i = 0; i < 16; i++) if (labels[i] == ch) return i;
      return 0;
   endfunction

   task automatic model_key(input int idx);
      byte ch;
      int  d;
      ch = labels[idx];
      if (ch >= 8'd48 && ch <= 8'd57) begin
         d = int'(ch) - 48;
         if (mq.size() < 4 && model_val() * 10 + d <= 9999) begin
            mq.push_back(d);
            merr = 1'b0;
         end else begin
            merr = 1'b1;
         end
      end else if (ch == "B") begin
         if (mq.size() == 0) merr = 1'b1;
         else begin
            void'(mq.pop_back());
            merr = 1'b0;
         end
      end else if (ch == "*") begin
         mq.delete();
         merr = 1'b0;
      end else if (ch == "#") begin
         merr = (mq.size() == 0);
      end
   endtask

   task automatic tap(input int idx, input int hold);
      repeat ($urandom_range(0, FRAME - 1)) @(negedge sys_clk);
      pressed[idx] = 1'b1;
      repeat (hold) @(negedge sys_clk);
      pressed[idx] = 1'b0;
      repeat (4 * FRAME) @(negedge sys_clk);
      model_key(idx);
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      n_tests++;
      if (key_col !== 4'b1110) begin n_failed++; $display("FAIL reset_col: got %b, expected 1110", key_col); end
      n_tests++;
      if ({temp_data, ack, digit_cnt, entry_err} !== 19'd0) begin
         n_failed++;
         $display("FAIL reset_outputs: temp=%0d ack=%b cnt=%0d err=%b, expected all 0", temp_data, ack, digit_cnt, entry_err);
      end
      sys_rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      n_tests++;
      if (key_col !== 4'b1110) begin n_failed++; $display("FAIL col_hold3: got %b, expected 1110", key_col); end
      @(negedge sys_clk);
      n_tests++;
      if (key_col !== 4'b1101) begin n_failed++; $display("FAIL col_rotate: got %b, expected 1101", key_col); end
   endtask

   task automatic test_entry_confirm();
      int w, hi, bad, any_ack;
      logic [13:0] prev_t;
      tap(idx_of("5"), 3 * FRAME + 8);
      tap(idx_of("0"), 3 * FRAME + 8);
      tap(idx_of("0"), 3 * FRAME + 8);
      n_tests++;
      if (temp_data !== 14'd500) begin n_failed++; $display("FAIL entry_value: got %0d, expected 500", temp_data); end
      n_tests++;
      if (digit_cnt !== 3'd3) begin n_failed++; $display("FAIL entry_cnt: got %0d, expected 3", digit_cnt); end
      pressed[idx_of("#")] = 1'b1;
      w = 0;
      prev_t = temp_data;
      while (ack !== 1'b1 && w < 200) begin prev_t = temp_data; @(negedge sys_clk); w++; end
      n_tests++;
      if (ack !== 1'b1) begin
         n_failed++;
         $display("FAIL ack_rise: ack=%b after %0d cycles, expected 1", ack, w);
      end else begin
         hi = 0; bad = 0;
         while (ack === 1'b1 && hi < 100) begin
            if (temp_data !== 14'd500) bad++;
            hi++;
            @(negedge sys_clk);
         end
         n_tests++;
         if (prev_t !== 14'd500) begin n_failed++; $display("FAIL pre_ack_value: got %0d, expected 500", prev_t); end
         n_tests++;
         if (hi != 8) begin n_failed++; $display("FAIL ack_len: got %0d cycles, expected 8", hi); end
         n_tests++;
         if (bad != 0) begin n_failed++; $display("FAIL ack_value: %0d cycles with temp_data!=500, expected 0", bad); end
         n_tests++;
         if (temp_data !== 14'd0 || digit_cnt !== 3'd0) begin
            n_failed++;
            $display("FAIL post_ack_clear: temp=%0d cnt=%0d, expected 0 0", temp_data, digit_cnt);
         end
      end
      mq.delete();
      merr = 1'b0;
      pressed = '0;
      pressed[idx_of("5")] = 1'b1;
      any_ack = 0;
      repeat (16) begin @(negedge sys_clk); if (ack === 1'b1) any_ack++; end
      pressed = '0;
      repeat (4 * FRAME) @(negedge sys_clk);
      n_tests++;
      if (any_ack != 0 || temp_data !== 14'd0 || digit_cnt !== 3'd0) begin
         n_failed++;
         $display("FAIL gap_ignore: ack_cycles=%0d temp=%0d cnt=%0d, expected 0 0 0", any_ack, temp_data, digit_cnt);
      end
   endtask

   task automatic test_limits();
      int any_ack;
      repeat (4) tap(idx_of("9"), 3 * FRAME + 4);
      n_tests++;
      if (temp_data !== 14'd9999 || digit_cnt !== 3'd4) begin
         n_failed++; $display("FAIL four_nines: temp=%0d cnt=%0d, expected 9999 4", temp_data, digit_cnt);
      end
      tap(idx_of("1"), 3 * FRAME + 4);
      n_tests++;
      if (entry_err !== 1'b1 || temp_data !== 14'd9999 || digit_cnt !== 3'd4) begin
         n_failed++; $display("FAIL fifth_digit: err=%b temp=%0d cnt=%0d, expected 1 9999 4", entry_err, temp_data, digit_cnt);
      end
      tap(idx_of("B"), 3 * FRAME + 4);
      n_tests++;
      if (temp_data !== 14'd999 || digit_cnt !== 3'd3) begin
         n_failed++; $display("FAIL backspace: temp=%0d cnt=%0d, expected 999 3", temp_data, digit_cnt);
      end
      tap(idx_of("*"), 3 * FRAME + 4);
      n_tests++;
      if (temp_data !== 14'd0 || digit_cnt !== 3'd0) begin
         n_failed++; $display("FAIL clear: temp=%0d cnt=%0d, expected 0 0", temp_data, digit_cnt);
      end
      pressed[idx_of("#")] = 1'b1;
      any_ack = 0;
      repeat (3 * FRAME + 8) begin @(negedge sys_clk); if (ack === 1'b1) any_ack++; end
      pressed = '0;
      repeat (4 * FRAME) begin @(negedge sys_clk); if (ack === 1'b1) any_ack++; end
      model_key(idx_of("#"));
      n_tests++;
      if (entry_err !== 1'b1 || any_ack != 0) begin
         n_failed++; $display("FAIL empty_confirm: err=%b ack_cycles=%0d, expected 1 0", entry_err, any_ack);
      end
   endtask

   task automatic test_debounce_ghost();
      tap(idx_of("*"), 3 * FRAME);
      pressed[idx_of("7")] = 1'b1;
      repeat (12) @(negedge sys_clk);
      pressed = '0;
      repeat (4 * FRAME) @(negedge sys_clk);
      n_tests++;
      if (temp_data !== 14'd0 || digit_cnt !== 3'd0) begin
         n_failed++; $display("FAIL short_press: temp=%0d cnt=%0d, expected 0 0", temp_data, digit_cnt);
      end
      pressed[idx_of("1")] = 1'b1;
      pressed[idx_of("2")] = 1'b1;
      repeat (5 * FRAME) @(negedge sys_clk);
      pressed = '0;
      repeat (4 * FRAME) @(negedge sys_clk);
      n_tests++;
      if (temp_data !== 14'd0 || digit_cnt !== 3'd0) begin
         n_failed++; $display("FAIL ghost: temp=%0d cnt=%0d, expected 0 0", temp_data, digit_cnt);
      end
      tap(idx_of("3"), 20 * FRAME);
      n_tests++;
      if (temp_data !== 14'd3 || digit_cnt !== 3'd1) begin
         n_failed++; $display("FAIL long_hold: temp=%0d cnt=%0d, expected 3 1", temp_data, digit_cnt);
      end
   endtask

   task automatic test_random();
      int sel, idx;
      for (int it = 0; it < 40; it++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 5 || sel == 9) idx = idx_of(byte'(48 + $urandom_range(0, 9)));
         else if (sel == 6)        idx = idx_of("B");
         else if (sel == 7)        idx = idx_of("*");
         else case ($urandom_range(0, 2))
            0:       idx = idx_of("A");
            1:       idx = idx_of("C");
            default: idx = idx_of("D");
         endcase
         tap(idx, 3 * FRAME + $urandom_range(0, FRAME));
         n_tests++;
         if (temp_data !== 14'(model_val()) || digit_cnt !== 3'(mq.size()) || entry_err !== merr) begin
            n_failed++;
            $display("FAIL random[%0d] key %s: temp=%0d cnt=%0d err=%b, expected %0d %0d %b",
                     it, string'(labels[idx]), temp_data, digit_cnt, entry_err, model_val(), mq.size(), merr);
         end
      end
   endtask

   task automatic test_reset_mid_ack();
      int w, hi;
      tap(idx_of("*"), 3 * FRAME);
      tap(idx_of("4"), 3 * FRAME);
      tap(idx_of("2"), 3 * FRAME);
      pressed[idx_of("#")] = 1'b1;
      w = 0;
      while (ack !== 1'b1 && w < 200) begin @(negedge sys_clk); w++; end
      n_tests++;
      if (ack !== 1'b1 || temp_data !== 14'd42) begin
         n_failed++; $display("FAIL mid_ack_rise: ack=%b temp=%0d, expected 1 42", ack, temp_data);
      end
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      pressed = '0;
      @(negedge sys_clk);
      n_tests++;
      if (ack !== 1'b0 || temp_data !== 14'd0 || digit_cnt !== 3'd0 || entry_err !== 1'b0) begin
         n_failed++;
         $display("FAIL mid_ack_reset: ack=%b temp=%0d cnt=%0d err=%b, expected 0 0 0 0", ack, temp_data, digit_cnt, entry_err);
      end
      mq.delete();
      merr = 1'b0;
      sys_rst_n = 1'b1;
      repeat (2 * FRAME) @(negedge sys_clk);
      tap(idx_of("1"), 3 * FRAME);
      tap(idx_of("2"), 3 * FRAME);
      pressed[idx_of("#")] = 1'b1;
      w = 0;
      while (ack !== 1'b1 && w < 200) begin @(negedge sys_clk); w++; end
      n_tests++;
      if (ack !== 1'b1 || temp_data !== 14'd12) begin
         n_failed++; $display("FAIL fresh_confirm: ack=%b temp=%0d, expected 1 12", ack, temp_data);
      end
      hi = 0;
      while (ack === 1'b1 && hi < 100) begin hi++; @(negedge sys_clk); end
      n_tests++;
      if (hi != 8) begin n_failed++; $display("FAIL fresh_ack_len: got %0d cycles, expected 8", hi); end
      pressed = '0;
      mq.delete();
      repeat (4 * FRAME) @(negedge sys_clk);
   endtask

   initial begin
      @(negedge sys_clk);
      test_reset();
      test_entry_confirm();
      test_limits();
      test_debounce_ghost();
      test_random();
      test_reset_mid_ack();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
